accum_stage_8: RTL and testbench

ACCUM_STAGE_8 -- requirements
Module: accum_stage_8

---
 rtl/accum_pkg.sv | 17 +
 rtl/full_adder_8.sv | 26 ++
 rtl/accum_stage_8.sv | 88 ++++++++
 tb/tb_accum_stage_8.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulate stage.
//   state_e            : ACC (collecting beats) / HOLD (result pending)
//   DATA_W             : data path width
//   DEFAULT_N_SAMPLES  : default number of beats summed per result
//   CNT_W              : beat counter width (covers N_SAMPLES up to 15)
package accum_pkg;

  localparam int unsigned DATA_W            = 8;
  localparam int unsigned DEFAULT_N_SAMPLES = 4;
  localparam int unsigned CNT_W             = 4;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/full_adder_8.sv
// 8-bit ripple-carry adder with carry-in tied to zero.
//   a, b : operands
//   s    : sum modulo 256
//   cout : carry out of bit 7
module full_adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s,
  output logic       cout
);

  logic [8:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[8];

endmodule

// File: rtl/accum_stage_8.sv
// Accumulates N_SAMPLES unsigned 8-bit beats into a modulo-256 sum with a
// sticky carry flag, then holds the result until downstream consumes it.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : upstream handshake, in_data is the operand
//   out_valid / out_ready: downstream handshake
//   out_sum, out_ovf     : accumulated sum and "any carry in batch" flag
module accum_stage_8
  import accum_pkg::*;
#(
  parameter int unsigned N_SAMPLES = DEFAULT_N_SAMPLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_SAMPLES - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] add_s;
  logic              add_cout;

  full_adder_8 u_adder (
    .a    (acc_q),
    .b    (in_data),
    .s    (add_s),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = add_s;
          ovf_d = ovf_q | add_cout;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LastCnt) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Ready is forced low while reset is held so nothing looks accepted during reset.
  assign in_ready  = rst_n && (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_accum_stage_8.sv
// Self-checking bench for accum_stage_8 (N_SAMPLES = 4).
module tb_accum_stage_8;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  // Reference model: true (unbounded) sum of the beats accepted in this batch.
  int run_total = 0;

  always #5 clk = ~clk;

  accum_stage_8 #(.N_SAMPLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Running sum/flag visible in ACC; a carry happened iff the true sum reached 256.
  task automatic check_running(input string tag);
    check({tag, "_sum"}, 32'(out_sum), 32'(run_total % 256));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(run_total >= 256));
  endtask

  task automatic send(input int unsigned v, input int gap_before, input string tag);
    int waited;
    waited = 0;
    in_valid = 1'b0;
    repeat (gap_before) begin
      check({tag, "_gap_valid"}, 32'(out_valid), 32'd0);
      step;
    end
    in_valid = 1'b1;
    in_data  = v[7:0];
    while (!in_ready && waited < 20) begin
      step;
      waited++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_no_early_valid"}, 32'(out_valid), 32'd0);
    step;
    run_total += int'(v);
    in_valid = 1'b0;
    check_running(tag);
  endtask

  task automatic expect_result(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_running({tag, "_res"});
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    run_total = 0;
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    check_running({tag, "_cleared"});
  endtask

  initial begin
    logic [7:0] held_sum;
    logic       held_ovf;

    // Reset
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    step;
    step;
    check("rst_in_ready2", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 10,20,30,40 back-to-back
    send(10, 0, "b1");
    send(20, 0, "b1");
    send(30, 0, "b1");
    send(40, 0, "b1");
    expect_result("b1");
    check("b1_sum_100", 32'(out_sum), 32'd100);
    consume("b1");

    // 100,100,100,0
    send(100, 0, "b2");
    send(100, 0, "b2");
    send(100, 0, "b2");
    send(0, 0, "b2");
    expect_result("b2");
    check("b2_sum_44", 32'(out_sum), 32'd44);
    check("b2_ovf", 32'(out_ovf), 32'd1);
    consume("b2");

    // 200,100,0,0: flag sets after beat 2 and sticks
    send(200, 0, "b3");
    check("b3_ovf_beat1", 32'(out_ovf), 32'd0);
    send(100, 0, "b3");
    check("b3_ovf_beat2", 32'(out_ovf), 32'd1);
    send(0, 0, "b3");
    send(0, 0, "b3");
    expect_result("b3");
    check("b3_sum_44", 32'(out_sum), 32'd44);
    check("b3_ovf_final", 32'(out_ovf), 32'd1);

    // Backpressure for 5 cycles with a pending input beat
    held_sum = out_sum;
    held_ovf = out_ovf;
    in_valid = 1'b1;
    in_data  = 8'd77;
    for (int i = 0; i < 5; i++) begin
      step;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum_stable", 32'(out_sum), 32'(held_sum));
      check("bp_ovf_stable", 32'(out_ovf), 32'(held_ovf));
    end
    // in_valid stays high through the consume edge: must not pass through
    consume("bp");
    in_valid = 1'b0;

    // Gaps of 2 cycles, then immediate handoff to the next batch
    send(1, 2, "g1");
    send(2, 2, "g1");
    send(3, 2, "g1");
    send(4, 2, "g1");
    expect_result("g1");
    check("g1_sum_10", 32'(out_sum), 32'd10);
    consume("g1");
    send(5, 0, "g2");
    send(5, 0, "g2");
    send(5, 0, "g2");
    send(5, 0, "g2");
    expect_result("g2");
    check("g2_sum_20", 32'(out_sum), 32'd20);
    check("g2_ovf", 32'(out_ovf), 32'd0);
    consume("g2");

    // Mid-batch reset discards the partial batch
    send(50, 0, "mr");
    send(60, 0, "mr");
    rst_n = 1'b0;
    #1;
    check("mr_in_ready_low", 32'(in_ready), 32'd0);
    step;
    rst_n = 1'b1;
    run_total = 0;
    #1;
    check("mr_in_ready", 32'(in_ready), 32'd1);
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check_running("mr_cleared");
    send(1, 0, "mr2");
    send(2, 0, "mr2");
    send(3, 0, "mr2");
    send(4, 0, "mr2");
    expect_result("mr2");
    check("mr2_sum_10", 32'(out_sum), 32'd10);
    check("mr2_ovf", 32'(out_ovf), 32'd0);

    // Reset while holding a result drops it
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    run_total = 0;
    #1;
    check("hr_out_valid", 32'(out_valid), 32'd0);
    check_running("hr_cleared");

    // Randomized batches with random gaps and consume delays
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < N; k++) begin
        send($urandom_range(0, 255), int'($urandom_range(0, 3)), "rnd");
      end
      expect_result("rnd");
      held_sum = out_sum;
      repeat ($urandom_range(0, 3)) begin
        step;
        check("rnd_hold_valid", 32'(out_valid), 32'd1);
        check("rnd_hold_sum", 32'(out_sum), 32'(held_sum));
      end
      consume("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
